conv1_frame_seq: RTL
====================

// Module: conv1_frame_seq
// PURPOSE
//   Sequences the first convolution layer over one 28x28 grayscale frame per output channel.
//   Reads pixels from the image RAM (1-cycle read latency) and streams them into the conv1 datapath with valid/img_in_en.
//   Selects the kernel channel and captures each valid conv1 output into the feature-map RAM at a linear address.
//   Sits between the host start/done handshake and the conv1 datapath, image RAM and feature-map RAM.
// PARAMETERS
//   IMG_W      28  input frame width = height, pixels
//   KERNEL_W   5   conv kernel width; OUT_W = IMG_W-KERNEL_W+1 = 24
//   NUM_CH     6   output channels; the frame is replayed once per channel
//   FLUSH_CYC  4   idle cycles after the last pixel to drain the conv pipeline
//   IMG_AW     10  image RAM address width (holds IMG_W*IMG_W = 784)
//   FM_AW      12  feature-map address width (holds NUM_CH*OUT_W*OUT_W = 3456)
// PORTS
//   clk           in   1       clock
//   rst_n         in   1       asynchronous, active-low reset
//   start         in   1       1-cycle request; accepted only in IDLE
//   abort         in   1       1-cycle request; terminates the run from any state
//   busy          out  1       high from the cycle after start is accepted until DONE
//   done          out  1       1-cycle pulse at the end of a successful or errored run
//   err           out  1       sticky output-count error; cleared on an accepted start
//   img_rd_en     out  1       image RAM read strobe
//   img_rd_addr   out  IMG_AW  image RAM address, row-major
//   img_rd_data   in   8       image RAM data, valid 1 cycle after img_rd_en
//   dp_clr        out  1       1-cycle pulse that clears the conv1 datapath counters and windows
//   conv_din      out  8       conv1 cnn_data_in
//   conv_din_vld  out  1       conv1 cnn_data_in_valid
//   conv_img_en   out  1       conv1 img_in_en
//   conv_ch_sel   out  3       active kernel channel, 0..NUM_CH-1
//   conv_dout_vld in   1       conv1 cnn_data_out_valid
//   fm_wr_en      out  1       feature-map write strobe (data comes straight from conv1 cnn_data_out)
//   fm_wr_addr    out  FM_AW   ch*OUT_W*OUT_W + out_cnt
// BEHAVIOUR
//   Reset: FSM=IDLE; outputs busy, done, err, img_rd_en, dp_clr, conv_din_vld, conv_img_en and fm_wr_en = 0; all counters, conv_ch_sel, addresses and conv_din = 0.
//   FSM states: IDLE, CLR, STREAM, FLUSH, CHK, DONE.
//   IDLE:   start & !abort -> CLR; err<=0; ch<=0.
//   CLR:    dp_clr=1 for exactly 1 cycle; pix_cnt<=0; out_cnt<=0 -> STREAM.
//   STREAM: img_rd_en=1 every cycle; img_rd_addr=pix_cnt, counting 0..IMG_W*IMG_W-1.
//           After the last address -> FLUSH.
//   Pixel pipeline: conv_din <= img_rd_data; conv_din_vld/conv_img_en are img_rd_en delayed by 1 cycle.
//           With start accepted at cycle T: first img_rd_en at T+2 and first conv_din_vld at T+3.
//   FLUSH:  no reads; counts FLUSH_CYC cycles -> CHK.
//   CHK (1 cycle): if out_cnt != OUT_W*OUT_W, set err.
//           If ch == NUM_CH-1 -> DONE; else ch++ and -> CLR.
//   DONE:   done=1 for 1 cycle; busy deasserts in the same cycle -> IDLE.
//   Capture: while in STREAM, FLUSH or CHK, conv_dout_vld=1 drives fm_wr_en=1 combinationally.
//           fm_wr_addr = ch*OUT_W*OUT_W + out_cnt; out_cnt then increments.
//   Overflow: conv_dout_vld with out_cnt == OUT_W*OUT_W sets err and suppresses fm_wr_en; out_cnt holds.
//   conv_dout_vld in IDLE or DONE is ignored (no write, no err).
//   conv_ch_sel = ch; it is stable for the whole CLR..CHK span of a channel.
//   Abort (any state except IDLE): next state is IDLE.
//           Same edge: img_rd_en, conv_din_vld, conv_img_en, busy <= 0; dp_clr pulses 1 cycle; no done pulse; err unchanged.
//   start while busy is ignored. start and abort in the same cycle: abort wins, no run starts.
//   Arithmetic: fm_wr_addr uses unsigned FM_AW-bit math; ch*OUT_W*OUT_W is a constant multiply, no wrap for the defaults.
//   rst_n asserted mid-run: all state returns to reset values immediately (asynchronous).
// TESTING
//   Ramp image (pixel[n] = n%256), NUM_CH=1, pulse start -> 784 reads at addr 0..783; conv_din_vld follows 1 cycle after each read.
//      Then 576 fm writes at addr 0..575, done pulse, err=0.
//   NUM_CH=6 -> 6 CLR pulses; conv_ch_sel steps 0..5; final fm_wr_addr = 3455; exactly 1 done pulse; busy high throughout.
//   Abort during STREAM at pix_cnt=300 -> next cycle busy=0, img_rd_en=0, dp_clr=1; no done pulse.
//      A following start runs a clean full frame.
//   Model forces 577 conv_dout_vld pulses -> 577th write suppressed, err=1 at done; next start clears err.
//   start during busy and start+abort together -> ignored: no extra reads, FSM unchanged / remains IDLE.
//   rst_n low for 2 cycles mid-FLUSH -> all outputs 0; after release the FSM stays IDLE until start.

Source files
------------

// File: rtl/conv1_frame_seq.sv
// conv1_frame_seq: replays a 28x28 frame through conv1 once per output channel and captures outputs to the feature-map RAM
module conv1_frame_seq #(
  parameter int IMG_W     = 28,
  parameter int KERNEL_W  = 5,
  parameter int NUM_CH    = 6,
  parameter int FLUSH_CYC = 4,
  parameter int IMG_AW    = 10,
  parameter int FM_AW     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              img_rd_en,
  output logic [IMG_AW-1:0] img_rd_addr,
  input  logic [7:0]        img_rd_data,
  output logic              dp_clr,
  output logic [7:0]        conv_din,
  output logic              conv_din_vld,
  output logic              conv_img_en,
  output logic [2:0]        conv_ch_sel,
  input  logic              conv_dout_vld,
  output logic              fm_wr_en,
  output logic [FM_AW-1:0]  fm_wr_addr
);
  localparam int OUT_W = IMG_W - KERNEL_W + 1;
  localparam int OUT_N = OUT_W * OUT_W;
  localparam int PIX_N = IMG_W * IMG_W;
  typedef enum logic [2:0] {IDLE, CLR, STREAM, FLUSH, CHK, DONE} state_t;
  state_t state, nxt;
  logic [IMG_AW-1:0] pix_cnt;
  logic [FM_AW-1:0] out_cnt;
  logic [2:0] ch;
  logic abort_q, cap, ovf;
  assign cap = conv_dout_vld && (state == STREAM || state == FLUSH || state == CHK);
  assign ovf = out_cnt == FM_AW'(OUT_N);
  assign busy = state == CLR || state == STREAM || state == FLUSH || state == CHK;
  assign done = state == DONE;
  assign img_rd_en = state == STREAM;
  assign img_rd_addr = pix_cnt;
  assign dp_clr = state == CLR || abort_q;
  assign conv_ch_sel = ch;
  assign fm_wr_en = cap && !ovf;
  assign fm_wr_addr = FM_AW'(ch) * FM_AW'(OUT_N) + out_cnt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start && !abort ? CLR : IDLE;
      CLR:     nxt = STREAM;
      STREAM:  nxt = pix_cnt == IMG_AW'(PIX_N - 1) ? FLUSH : STREAM;
      FLUSH:   nxt = pix_cnt == IMG_AW'(FLUSH_CYC - 1) ? CHK : FLUSH;
      CHK:     nxt = ch == 3'(NUM_CH - 1) ? DONE : CLR;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      out_cnt      <= '0;
      ch           <= '0;
      err          <= 1'b0;
      abort_q      <= 1'b0;
      conv_din     <= '0;
      conv_din_vld <= 1'b0;
      conv_img_en  <= 1'b0;
    end else begin
      state        <= nxt;
      abort_q      <= abort && state != IDLE;
      conv_din     <= img_rd_data;
      conv_din_vld <= img_rd_en && !abort;
      conv_img_en  <= img_rd_en && !abort;
      if (state == IDLE && nxt == CLR) begin
        err <= 1'b0;
        ch  <= '0;
      end
      if (state == CLR) begin
        pix_cnt <= '0;
        out_cnt <= '0;
      end else if (state == STREAM) begin
        pix_cnt <= nxt == FLUSH ? '0 : pix_cnt + 1'b1;
      end else if (state == FLUSH) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (cap && !ovf) out_cnt <= out_cnt + 1'b1;
      if ((cap && ovf) || (state == CHK && !ovf)) err <= 1'b1;
      if (state == CHK && nxt == CLR) ch <= ch + 3'd1;
    end
  end
endmodule
